// File: rtl/arb_pkg.sv
// Shared types and constants for the IFU/LSU AXI master arbiter.
package arb_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned STRB_W  = 4;
  localparam int unsigned CNT_W   = 16;

  // Unit indices into the request/grant vectors and last_grant encoding
  localparam logic UNIT_IFU = 1'b0;
  localparam logic UNIT_LSU = 1'b1;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    G_IFU_R = 4'b0010,
    G_LSU_R = 4'b0100,
    G_LSU_W = 4'b1000
  } arb_state_e;

endpackage

// File: rtl/axi_master_arbiter_rr_pick2.sv
// Two-requester round-robin picker: on a tie, the unit not granted last wins.
module rr_pick2
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt           = 2'b00;
    gnt[UNIT_IFU] = req[UNIT_IFU] & (~req[UNIT_LSU] | (last_grant == UNIT_LSU));
    gnt[UNIT_LSU] = req[UNIT_LSU] & (~req[UNIT_IFU] | (last_grant == UNIT_IFU));
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// Shares one AXI4 master port between IFU (read) and LSU (read/write), one
// whole transaction per grant. Optional watchdog under `ARB_TIMEOUT_EN.
module axi_master_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ID_W           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // IFU read
  input  logic [ID_W-1:0]      ifu_arid,
  input  logic [ADDR_W-1:0]    ifu_araddr,
  input  logic [LEN_W-1:0]     ifu_arlen,
  input  logic [SIZE_W-1:0]    ifu_arsize,
  input  logic [BURST_W-1:0]   ifu_arburst,
  input  logic                 ifu_arvalid,
  output logic                 ifu_arready,
  output logic [ID_W-1:0]      ifu_rid,
  output logic [DATA_W-1:0]    ifu_rdata,
  output logic [RESP_W-1:0]    ifu_rresp,
  output logic                 ifu_rlast,
  output logic                 ifu_rvalid,
  input  logic                 ifu_rready,
  // LSU read
  input  logic [ID_W-1:0]      lsu_arid,
  input  logic [ADDR_W-1:0]    lsu_araddr,
  input  logic [LEN_W-1:0]     lsu_arlen,
  input  logic [SIZE_W-1:0]    lsu_arsize,
  input  logic [BURST_W-1:0]   lsu_arburst,
  input  logic                 lsu_arvalid,
  output logic                 lsu_arready,
  output logic [ID_W-1:0]      lsu_rid,
  output logic [DATA_W-1:0]    lsu_rdata,
  output logic [RESP_W-1:0]    lsu_rresp,
  output logic                 lsu_rlast,
  output logic                 lsu_rvalid,
  input  logic                 lsu_rready,
  // LSU write
  input  logic [ID_W-1:0]      lsu_awid,
  input  logic [ADDR_W-1:0]    lsu_awaddr,
  input  logic [LEN_W-1:0]     lsu_awlen,
  input  logic [SIZE_W-1:0]    lsu_awsize,
  input  logic [BURST_W-1:0]   lsu_awburst,
  input  logic                 lsu_awvalid,
  output logic                 lsu_awready,
  input  logic [ID_W-1:0]      lsu_wid,
  input  logic [DATA_W-1:0]    lsu_wdata,
  input  logic [STRB_W-1:0]    lsu_wstrb,
  input  logic                 lsu_wlast,
  input  logic                 lsu_wvalid,
  output logic                 lsu_wready,
  output logic [ID_W-1:0]      lsu_bid,
  output logic [RESP_W-1:0]    lsu_bresp,
  output logic                 lsu_bvalid,
  input  logic                 lsu_bready,
  // Downstream master port
  output logic [ID_W-1:0]      m_arid,
  output logic [ADDR_W-1:0]    m_araddr,
  output logic [LEN_W-1:0]     m_arlen,
  output logic [SIZE_W-1:0]    m_arsize,
  output logic [BURST_W-1:0]   m_arburst,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  input  logic [ID_W-1:0]      m_rid,
  input  logic [DATA_W-1:0]    m_rdata,
  input  logic [RESP_W-1:0]    m_rresp,
  input  logic                 m_rlast,
  input  logic                 m_rvalid,
  output logic                 m_rready,
  output logic [ID_W-1:0]      m_awid,
  output logic [ADDR_W-1:0]    m_awaddr,
  output logic [LEN_W-1:0]     m_awlen,
  output logic [SIZE_W-1:0]    m_awsize,
  output logic [BURST_W-1:0]   m_awburst,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [ID_W-1:0]      m_wid,
  output logic [DATA_W-1:0]    m_wdata,
  output logic [STRB_W-1:0]    m_wstrb,
  output logic                 m_wlast,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  input  logic [ID_W-1:0]      m_bid,
  input  logic [RESP_W-1:0]    m_bresp,
  input  logic                 m_bvalid,
  output logic                 m_bready,
  output logic                 busy_o
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                 timeout_o
`endif
);

  arb_state_e state_q, state_d;
  arb_state_e mux_state;
  logic       last_grant_q, last_grant_d;
  logic       req_lsu_w;
  logic [1:0] req, gnt;

  assign req_lsu_w     = lsu_awvalid | lsu_wvalid;
  assign req[UNIT_IFU] = ifu_arvalid;
  assign req[UNIT_LSU] = lsu_arvalid | req_lsu_w;

  rr_pick2 u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= UNIT_IFU;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Grant selection in IDLE; release on the final R beat or the B handshake
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (gnt[UNIT_LSU]) begin
          state_d      = req_lsu_w ? G_LSU_W : G_LSU_R;
          last_grant_d = UNIT_LSU;
        end else if (gnt[UNIT_IFU]) begin
          state_d      = G_IFU_R;
          last_grant_d = UNIT_IFU;
        end
      end
      G_IFU_R, G_LSU_R: if (m_rvalid && m_rready && m_rlast) state_d = IDLE;
      G_LSU_W:          if (m_bvalid && m_bready) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  // Reset forces the channel view to IDLE so no handshake leaks while rst_i is high
  assign mux_state = rst_i ? IDLE : state_q;

  always_comb begin
    m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    m_arvalid = 1'b0; m_rready = 1'b0;
    m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
    m_awvalid = 1'b0;
    m_wid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = 1'b0; m_wvalid = 1'b0;
    m_bready = 1'b0;
    ifu_arready = 1'b0; ifu_rid = '0; ifu_rdata = '0; ifu_rresp = '0;
    ifu_rlast = 1'b0; ifu_rvalid = 1'b0;
    lsu_arready = 1'b0; lsu_rid = '0; lsu_rdata = '0; lsu_rresp = '0;
    lsu_rlast = 1'b0; lsu_rvalid = 1'b0;
    lsu_awready = 1'b0; lsu_wready = 1'b0;
    lsu_bid = '0; lsu_bresp = '0; lsu_bvalid = 1'b0;
    case (mux_state)
      G_IFU_R: begin
        m_arid = ifu_arid; m_araddr = ifu_araddr; m_arlen = ifu_arlen;
        m_arsize = ifu_arsize; m_arburst = ifu_arburst; m_arvalid = ifu_arvalid;
        m_rready = ifu_rready;
        ifu_arready = m_arready; ifu_rid = m_rid; ifu_rdata = m_rdata;
        ifu_rresp = m_rresp; ifu_rlast = m_rlast; ifu_rvalid = m_rvalid;
      end
      G_LSU_R: begin
        m_arid = lsu_arid; m_araddr = lsu_araddr; m_arlen = lsu_arlen;
        m_arsize = lsu_arsize; m_arburst = lsu_arburst; m_arvalid = lsu_arvalid;
        m_rready = lsu_rready;
        lsu_arready = m_arready; lsu_rid = m_rid; lsu_rdata = m_rdata;
        lsu_rresp = m_rresp; lsu_rlast = m_rlast; lsu_rvalid = m_rvalid;
      end
      G_LSU_W: begin
        m_awid = lsu_awid; m_awaddr = lsu_awaddr; m_awlen = lsu_awlen;
        m_awsize = lsu_awsize; m_awburst = lsu_awburst; m_awvalid = lsu_awvalid;
        m_wid = lsu_wid; m_wdata = lsu_wdata; m_wstrb = lsu_wstrb;
        m_wlast = lsu_wlast; m_wvalid = lsu_wvalid;
        m_bready = lsu_bready;
        lsu_awready = m_awready; lsu_wready = m_wready;
        lsu_bid = m_bid; lsu_bresp = m_bresp; lsu_bvalid = m_bvalid;
      end
      default: ;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Counter is zero in IDLE, so every grant starts counting from zero
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

`ifdef SIMULATION
  always_ff @(posedge clk_i) begin
    if (!rst_i && !timeout_q && timeout_d) begin
      $display("arbiter timeout");
      $finish;
    end
  end
`endif
`else
  localparam int unsigned timeout_unused = TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed self-checking bench for axi_master_arbiter (define ARB_TIMEOUT_EN
// to also exercise the watchdog).
module tb_axi_master_arbiter;

  localparam int unsigned ID_W = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic [ID_W-1:0] ifu_arid, ifu_rid, lsu_arid, lsu_rid, lsu_awid, lsu_wid, lsu_bid;
  logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, ifu_rdata, lsu_rdata, lsu_wdata;
  logic [7:0]  ifu_arlen, lsu_arlen, lsu_awlen;
  logic [2:0]  ifu_arsize, lsu_arsize, lsu_awsize;
  logic [1:0]  ifu_arburst, lsu_arburst, lsu_awburst, ifu_rresp, lsu_rresp, lsu_bresp;
  logic [3:0]  lsu_wstrb;
  logic ifu_arvalid, ifu_arready, ifu_rlast, ifu_rvalid, ifu_rready;
  logic lsu_arvalid, lsu_arready, lsu_rlast, lsu_rvalid, lsu_rready;
  logic lsu_awvalid, lsu_awready, lsu_wlast, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic [ID_W-1:0] m_arid, m_rid, m_awid, m_wid, m_bid;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize;
  logic [1:0]  m_arburst, m_rresp, m_awburst, m_bresp;
  logic [3:0]  m_wstrb;
  logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, m_awvalid, m_awready;
  logic m_wlast, m_wvalid, m_wready, m_bvalid, m_bready, busy_o;
`ifdef ARB_TIMEOUT_EN
  logic timeout_o;
`endif

  axi_master_arbiter #(.ID_W(ID_W), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifu_arid(ifu_arid), .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
    .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst), .ifu_arvalid(ifu_arvalid),
    .ifu_arready(ifu_arready), .ifu_rid(ifu_rid), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rvalid(ifu_rvalid),
    .ifu_rready(ifu_rready),
    .lsu_arid(lsu_arid), .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen),
    .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst), .lsu_arvalid(lsu_arvalid),
    .lsu_arready(lsu_arready), .lsu_rid(lsu_rid), .lsu_rdata(lsu_rdata),
    .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rvalid(lsu_rvalid),
    .lsu_rready(lsu_rready),
    .lsu_awid(lsu_awid), .lsu_awaddr(lsu_awaddr), .lsu_awlen(lsu_awlen),
    .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst), .lsu_awvalid(lsu_awvalid),
    .lsu_awready(lsu_awready), .lsu_wid(lsu_wid), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast), .lsu_wvalid(lsu_wvalid),
    .lsu_wready(lsu_wready), .lsu_bid(lsu_bid), .lsu_bresp(lsu_bresp),
    .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .busy_o(busy_o)
`ifdef ARB_TIMEOUT_EN
    , .timeout_o(timeout_o)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then let registered state settle before driving/checking
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Apply a single-beat R response on the current cycle
  task automatic r_beat(input logic [31:0] data, input logic last);
    m_rvalid = 1'b1; m_rdata = data; m_rlast = last; m_rresp = 2'b00; m_rid = 4'h1;
  endtask

  initial begin
    rst_i = 1'b1;
    ifu_arid = 4'h1; ifu_araddr = '0; ifu_arlen = '0; ifu_arsize = 3'd2;
    ifu_arburst = 2'b01; ifu_arvalid = 1'b0; ifu_rready = 1'b1;
    lsu_arid = 4'h2; lsu_araddr = '0; lsu_arlen = '0; lsu_arsize = 3'd2;
    lsu_arburst = 2'b01; lsu_arvalid = 1'b0; lsu_rready = 1'b1;
    lsu_awid = 4'h3; lsu_awaddr = '0; lsu_awlen = '0; lsu_awsize = 3'd2;
    lsu_awburst = 2'b01; lsu_awvalid = 1'b0;
    lsu_wid = 4'h3; lsu_wdata = '0; lsu_wstrb = '0; lsu_wlast = 1'b0; lsu_wvalid = 1'b0;
    lsu_bready = 1'b1;
    m_arready = 1'b1; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    m_rvalid = 1'b0; m_awready = 1'b1; m_wready = 1'b1;
    m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    cyc(); cyc();
    rst_i = 1'b0;
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_ifu_arready", 64'(ifu_arready), 64'd0);

    // IFU single read
    ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000;
    #1;
    chk("t1_idle_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("t1_idle_ifu_arready", 64'(ifu_arready), 64'd0);
    cyc();
    chk("t1_m_arvalid", 64'(m_arvalid), 64'd1);
    chk("t1_m_araddr", 64'(m_araddr), 64'h3000_0000);
    chk("t1_ifu_arready", 64'(ifu_arready), 64'd1);
    chk("t1_lsu_arready", 64'(lsu_arready), 64'd0);
    chk("t1_busy", 64'(busy_o), 64'd1);
    cyc();
    ifu_arvalid = 1'b0; r_beat(32'hDEAD_BEEF, 1'b1);
    #1;
    chk("t1_ifu_rvalid", 64'(ifu_rvalid), 64'd1);
    chk("t1_ifu_rdata", 64'(ifu_rdata), 64'hDEAD_BEEF);
    chk("t1_m_rready", 64'(m_rready), 64'd1);
    chk("t1_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    chk("t1_busy_after", 64'(busy_o), 64'd0);

    // Tie after reset: LSU first, IFU after the LSU rlast
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_0100;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_0200;
    cyc();
    chk("t2_m_araddr_lsu", 64'(m_araddr), 64'h200);
    chk("t2_lsu_arready", 64'(lsu_arready), 64'd1);
    chk("t2_ifu_arready", 64'(ifu_arready), 64'd0);
    cyc();
    lsu_arvalid = 1'b0; r_beat(32'h1111_1111, 1'b1);
    #1;
    chk("t2_lsu_rdata", 64'(lsu_rdata), 64'h1111_1111);
    chk("t2_ifu_rvalid", 64'(ifu_rvalid), 64'd0);
    cyc();
    m_rvalid = 1'b0;
    #1;
    chk("t2_gap_busy", 64'(busy_o), 64'd0);
    chk("t2_gap_m_arvalid", 64'(m_arvalid), 64'd0);
    cyc();
    chk("t2_m_araddr_ifu", 64'(m_araddr), 64'h100);
    chk("t2_ifu_arready2", 64'(ifu_arready), 64'd1);
    cyc();
    ifu_arvalid = 1'b0; r_beat(32'h2222_2222, 1'b1);
    #1;
    chk("t2_ifu_rdata", 64'(ifu_rdata), 64'h2222_2222);
    cyc();
    m_rvalid = 1'b0;
    // LSU-only read leaves last_grant at LSU, so the following tie goes to the IFU
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_0300;
    cyc(); cyc();
    lsu_arvalid = 1'b0; r_beat(32'h3333_3333, 1'b1);
    cyc();
    m_rvalid = 1'b0;
    ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_0400;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_0500;
    cyc();
    chk("t2b_m_araddr_ifu", 64'(m_araddr), 64'h400);
    chk("t2b_lsu_arready", 64'(lsu_arready), 64'd0);
    cyc();
    ifu_arvalid = 1'b0; r_beat(32'h4444_4444, 1'b1);
    cyc();
    m_rvalid = 1'b0;
    #1;
    chk("t2b_gap_busy", 64'(busy_o), 64'd0);
    cyc();
    chk("t2b_m_araddr_lsu", 64'(m_araddr), 64'h500);
    cyc();
    lsu_arvalid = 1'b0; r_beat(32'h5555_5555, 1'b1);
    cyc();
    m_rvalid = 1'b0;

    // LSU write with 5-cycle B delay; IFU contends (last_grant = LSU, but IFU not yet requesting)
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_0004;
    lsu_wvalid = 1'b1; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'b1111; lsu_wlast = 1'b1;
    cyc();
    ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_0600;
    #1;
    chk("t3_m_awvalid", 64'(m_awvalid), 64'd1);
    chk("t3_m_awaddr", 64'(m_awaddr), 64'h8000_0004);
    chk("t3_m_wdata", 64'(m_wdata), 64'h1234_5678);
    chk("t3_m_wstrb", 64'(m_wstrb), 64'hF);
    chk("t3_lsu_wready", 64'(lsu_wready), 64'd1);
    chk("t3_m_arvalid", 64'(m_arvalid), 64'd0);
    cyc();
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_wait_ifu_arready", 64'(ifu_arready), 64'd0);
      cyc();
    end
    m_bvalid = 1'b1; m_bresp = 2'b00; m_bid = 4'h3;
    #1;
    chk("t3_lsu_bvalid", 64'(lsu_bvalid), 64'd1);
    chk("t3_lsu_bresp", 64'(lsu_bresp), 64'd0);
    chk("t3_lsu_bid", 64'(lsu_bid), 64'h3);
    chk("t3_m_bready", 64'(m_bready), 64'd1);
    chk("t3_b_ifu_arready", 64'(ifu_arready), 64'd0);
    cyc();
    m_bvalid = 1'b0; m_bid = '0;
    #1;
    chk("t3_rel_ifu_arready", 64'(ifu_arready), 64'd0);
    chk("t3_rel_busy", 64'(busy_o), 64'd0);
    cyc();
    chk("t3_ifu_granted", 64'(ifu_arready), 64'd1);
    cyc();
    ifu_arvalid = 1'b0; r_beat(32'h6666_6666, 1'b1);
    cyc();
    m_rvalid = 1'b0;

    // IFU 4-beat burst with LSU request arriving mid-burst
    ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_1000; ifu_arlen = 8'd3;
    cyc();
    chk("t4_m_arlen", 64'(m_arlen), 64'd3);
    cyc();
    ifu_arvalid = 1'b0; ifu_arlen = '0;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_2000;
    for (int i = 0; i < 4; i++) begin
      r_beat(32'hA0 + 32'(i), (i == 3));
      #1;
      chk("t4_ifu_rdata", 64'(ifu_rdata), 64'hA0 + 64'(i));
      chk("t4_ifu_rlast", 64'(ifu_rlast), (i == 3) ? 64'd1 : 64'd0);
      chk("t4_lsu_arready", 64'(lsu_arready), 64'd0);
      cyc();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    chk("t4_idle_busy", 64'(busy_o), 64'd0);
    cyc();
    chk("t4_lsu_granted", 64'(lsu_arready), 64'd1);
    chk("t4_m_araddr", 64'(m_araddr), 64'h2000);
    cyc();
    lsu_arvalid = 1'b0; r_beat(32'h7777_7777, 1'b1);
    cyc();
    m_rvalid = 1'b0;

    // Reset in G_LSU_W with W accepted, B pending (last_grant = LSU before reset)
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_0008;
    lsu_wvalid = 1'b1; lsu_wdata = 32'hCAFE_0000; lsu_wstrb = 4'b0011;
    cyc();
    chk("t5_m_wvalid", 64'(m_wvalid), 64'd1);
    cyc();
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("t5_during_rst_m_bready", 64'(m_bready), 64'd0);
    cyc();
    rst_i = 1'b0;
    #1;
    chk("t5_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("t5_m_awvalid", 64'(m_awvalid), 64'd0);
    chk("t5_m_wvalid0", 64'(m_wvalid), 64'd0);
    chk("t5_m_bready", 64'(m_bready), 64'd0);
    chk("t5_busy", 64'(busy_o), 64'd0);
    ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_3000;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_4000;
    cyc();
    chk("t5_tie_lsu_arready", 64'(lsu_arready), 64'd1);
    chk("t5_tie_ifu_arready", 64'(ifu_arready), 64'd0);
    chk("t5_tie_m_araddr", 64'(m_araddr), 64'h4000);
    cyc();
    lsu_arvalid = 1'b0; r_beat(32'h8888_8888, 1'b1);
    cyc();
    m_rvalid = 1'b0;
    cyc();
    chk("t5_ifu_after", 64'(ifu_arready), 64'd1);
    cyc();
    ifu_arvalid = 1'b0; r_beat(32'h9999_9999, 1'b1);
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // Slave never returns R: watchdog fires 16 cycles after the grant
    ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_5000;
    cyc();
    chk("t6_grant_timeout", 64'(timeout_o), 64'd0);
    cyc();
    ifu_arvalid = 1'b0;
    for (int i = 2; i < 16; i++) cyc();
    #1;
    chk("t6_pre_timeout", 64'(timeout_o), 64'd0);
    cyc();
    chk("t6_timeout", 64'(timeout_o), 64'd1);
    chk("t6_still_busy", 64'(busy_o), 64'd1);
    cyc(); cyc();
    chk("t6_sticky", 64'(timeout_o), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
